alu_seq: RTL
============

# alu_seq

Parametrised, handshaked successor to the 4-bit combinational ALU in the simple CPU datapath. It adds a registered result with carry/zero flags, seven single-cycle operations and an iterative multi-cycle multiply. Operands enter through a valid/ready handshake. The result is held until the consumer (register-file write-back) accepts it.

## Interface
- WIDTH, 4: operand and result width; must be ≥ 2 and a power of two.
- SHW, $clog2(WIDTH): shift-amount bits taken from B; derived, not overridden.
- clk  in  1  rising-edge clock.
- n_reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block accepts the operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  operation code (see Operation).
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- d  out  WIDTH  result.
- carry  out  1  carry/borrow/shift-out/overflow flag.
- zero  out  1  set when d == 0.

## Operation
- Reset behaviour: one clock (clk); reset is asynchronous, active-low (n_reset). While n_reset is low, the block is in IDLE and d, carry, zero and out_valid are all 0.
- Op codes:
  - 000 ADD: d = a+b; carry = carry-out.
  - 001 SUB: d = a−b (mod 2^WIDTH); carry = 1 iff a < b unsigned.
  - 010 AND, 011 OR, 100 XOR: carry = 0.
  - 101 SHL by b[SHW-1:0]; 110 SHR (logical) by b[SHW-1:0]: carry = last bit shifted out; shift amount 0 gives carry = 0.
  - 111 MUL: unsigned; d = low WIDTH bits of a*b; carry = 1 iff the high half is nonzero.
- zero is computed from the final d for every op.
- FSM states and transitions:
  - IDLE: in_ready = 1.
    - Accept with a non-MUL op → DONE.
    - Accept with MUL → BUSY, step counter cleared.
  - BUSY: in_ready = 0. One shift-add step per cycle. After WIDTH steps → DONE.
  - DONE: out_valid = 1; d, carry and zero are held stable.
    - out_ready = 1 → result is handed off; in_ready = 1 in the same cycle.
    - New accept in that cycle → DONE (non-MUL) or BUSY (MUL).
    - No new accept → IDLE.
    - out_ready = 0 → stay in DONE; in_ready = 0.
- Accept: in_valid & in_ready at a rising edge. Operands are captured at that edge; later changes on a, b or op are ignored.
- Outputs are registered only. There is no combinational path from a, b or op to d.

## Timing
- Non-MUL latency: accept at edge N; out_valid = 1 and the result is valid after edge N.
- MUL latency: accept at edge N; BUSY during edges N+1..N+WIDTH; out_valid = 1 after edge N+WIDTH. For WIDTH = 4 this is 4 cycles.
- Throughput:
  - One non-MUL op per cycle with out_ready held high.
  - MUL blocks input for WIDTH cycles.
- Backpressure: while out_valid & !out_ready, all outputs stay bit-stable and in_ready = 0.
- Simultaneous hand-off and accept in DONE is legal and loses no cycle.
- n_reset asserted mid-MUL or in DONE: the operation is aborted and no result is produced. After n_reset is released, the first accept is possible at the first rising edge.
- Step counter is SHW+1 bits, so it can reach WIDTH.

## Structure
- Package alu_pkg holds:
  - the op encodings (OP_ADD … OP_MUL) as a 3-bit enum;
  - the FSM state enum (IDLE, BUSY, DONE).
- Sub-module alu_mul_iter holds the shift-add multiplier:
  - inputs: start, a, b;
  - registers: a 2·WIDTH product and a step counter;
  - outputs: done, product.
- The top level holds the combinational single-cycle datapath, the FSM, and the output/flag registers.

## Test plan
- Reset and ADD (WIDTH = 4): during reset, all outputs are 0. Then ADD a = 1110, b = 0101 → one cycle later d = 0011, carry = 1, zero = 0, out_valid = 1.
- SUB/zero: SUB 0100−0001 → d = 0011, carry = 0. SUB 0001−0001 → d = 0000, zero = 1. SUB 0000−0001 → d = 1111, carry = 1.
- Shifts: SHL 1010 by 01 → d = 0100, carry = 1. SHR 1010 by 00 → d = 1010, carry = 0.
- MUL latency: MUL 0011×0101 → in_ready = 0 for 4 cycles, then d = 1111, carry = 0. MUL 1000×0010 → d = 0000, carry = 1, zero = 1.
- Backpressure and back-to-back:
  - Hold out_ready = 0 for 3 cycles with in_valid = 1 → d is stable and in_ready = 0.
  - Then raise out_ready → the result is handed off and the next op is accepted in the same cycle.
  - Streaming ANDs with out_ready = 1 → one result per cycle.
- Reset mid-MUL: drop n_reset during cycle 2 of BUSY → out_valid = 0 and d = 0 immediately. After release, a new ADD 0001+0001 → d = 0010.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: op codes and control states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // MUL is the only op that takes the multi-cycle path.
  function automatic logic is_mul(input op_e op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle.
// product/done describe the value after the step taken this cycle, so the
// caller can latch the final product on the same edge as the last step.
module alu_mul_iter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int SHW = $clog2(WIDTH);
  localparam int PW  = 2 * WIDTH;
  localparam logic [SHW:0] CNT_ONE  = (SHW + 1)'(1);
  localparam logic [SHW:0] CNT_LAST = (SHW + 1)'(WIDTH - 1);

  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_prod;
  logic [SHW:0]     r_cnt;
  logic             r_active;

  logic [PW-1:0]    w_prod_next;
  logic             w_last;

  assign w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
  assign w_last      = r_active && (r_cnt == CNT_LAST);

  assign done    = w_last;
  assign product = w_prod_next;

  // Load operands on start, then add/shift once per cycle for WIDTH steps.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_prod   <= w_prod_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_ONE;
      if (w_last) r_active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ops plus an iterative multiply,
// with registered result and carry/zero flags held until accepted.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             carry,
  output logic             zero
);

  state_e r_state;
  state_e w_state_next;

  logic [WIDTH-1:0] r_d;
  logic             r_carry;
  logic             r_zero;

  op_e              w_op;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [WIDTH:0]   w_alu_ext;   // {carry, result}
  logic [WIDTH:0]   w_mul_ext;   // {carry, result}
  logic [WIDTH:0]   w_load_ext;

  logic             w_accept;
  logic             w_mul_start;
  logic             w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;
  logic             w_load_alu;
  logic             w_load_mul;

  assign w_op    = op_e'(op);
  assign w_shamt = b[SHW-1:0];
  // The extra bit catches the last bit shifted out; a zero shift leaves it 0.
  assign w_shl   = {1'b0, a} << w_shamt;
  assign w_shr   = {a, 1'b0} >> w_shamt;

  // Single-cycle datapath producing {carry, result} for the non-MUL ops.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch.
    w_alu_ext = '0;
    unique case (w_op)
      OP_ADD:  w_alu_ext = {1'b0, a} + {1'b0, b};
      OP_SUB:  w_alu_ext = {1'b0, a} - {1'b0, b};  // top bit is the borrow
      OP_AND:  w_alu_ext = {1'b0, a & b};
      OP_OR:   w_alu_ext = {1'b0, a | b};
      OP_XOR:  w_alu_ext = {1'b0, a ^ b};
      OP_SHL:  w_alu_ext = w_shl;
      OP_SHR:  w_alu_ext = {w_shr[0], w_shr[WIDTH:1]};
      default: w_alu_ext = '0;                      // MUL uses the multiplier
    endcase
  end

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .n_reset (n_reset),
    .start   (w_mul_start),
    .a       (a),
    .b       (b),
    .done    (w_mul_done),
    .product (w_mul_prod)
  );

  assign w_mul_ext  = {|w_mul_prod[2*WIDTH-1:WIDTH], w_mul_prod[WIDTH-1:0]};
  assign w_load_ext = w_load_mul ? w_mul_ext : w_alu_ext;

  // Control: handshake decode and next-state selection.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    w_mul_start  = 1'b0;
    w_load_alu   = 1'b0;
    w_load_mul   = 1'b0;

    unique case (r_state)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;   // a hand-off frees the slot this cycle
      default: in_ready = 1'b0;
    endcase

    w_accept = in_valid & in_ready;

    unique case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          if (is_mul(w_op)) begin
            w_state_next = BUSY;
            w_mul_start  = 1'b1;
          end else begin
            w_state_next = DONE;
            w_load_alu   = 1'b1;
          end
        end else if (r_state == DONE && out_ready) begin
          w_state_next = IDLE;
        end
      end
      BUSY: begin
        if (w_mul_done) begin
          w_state_next = DONE;
          w_load_mul   = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Result and flag registers; they only change when a new result lands.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_d     <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_load_alu || w_load_mul) begin
      r_d     <= w_load_ext[WIDTH-1:0];
      r_carry <= w_load_ext[WIDTH];
      r_zero  <= (w_load_ext[WIDTH-1:0] == '0);
    end
  end

  assign d         = r_d;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign out_valid = (r_state == DONE);

endmodule
